// File: rtl/tl_cntr_if.sv
// Sensor/light bundle between the intersection environment and the
// two-road traffic light controller.
//   master : the environment side (drives sensors, observes lights)
//   slave  : the controller side (samples sensors, drives lights)
interface tl_cntr_if;
    logic       Ta;   // 1 = traffic present on road A
    logic       Tb;   // 1 = traffic present on road B
    logic [1:0] La;   // road A light: 00 green, 01 yellow, 10 red
    logic [1:0] Lb;   // road B light: same encoding as La

    modport master (
        output Ta,
        output Tb,
        input  La,
        input  Lb
    );

    modport slave (
        input  Ta,
        input  Tb,
        output La,
        output Lb
    );
endinterface

// File: rtl/tl_cntr.sv
// Two-road traffic light controller (road A / road B), Moore FSM.
// The 2-bit state register is updated from explicit next-state equations,
// and the light heads are decoded from the state register alone.
//
// Build option:
//   TL_CNTR_STATE_OUT_EN - when defined, exposes the current state register
//                          (S1:S0) on output port "state" for debug.
//
// Note: reset_n is active HIGH despite its name; it is sampled on the
// rising edge of clk and takes priority over the sensors.
module tl_cntr (
    input  logic       clk,
    input  logic       reset_n,
    tl_cntr_if.slave   tl
`ifdef TL_CNTR_STATE_OUT_EN
    ,
    output logic [1:0] state
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'b00,   // A green,  B red
        S1 = 2'b01,   // A yellow, B red
        S2 = 2'b10,   // A red,    B green
        S3 = 2'b11    // A red,    B yellow
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Individual state bits, named to match the next-state/output equations.
    logic s1;
    logic s0;
    logic s1_next;
    logic s0_next;

    assign s1 = state_reg[1];
    assign s0 = state_reg[0];

    // State register: reset forces S0 on the edge it is sampled.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: greens hold while their sensor is 1, yellows last one cycle.
    always_comb begin
        s1_next    = 1'b0;
        s0_next    = 1'b0;
        s1_next    = s1 ^ s0;
        s0_next    = (~s1 & ~s0 & ~tl.Ta) | (s1 & ~s0 & ~tl.Tb);
        state_next = state_t'({s1_next, s0_next});
    end

    // Output decode from the state register only; code 2'b11 never appears.
    always_comb begin
        tl.La    = 2'b10;
        tl.Lb    = 2'b10;
        tl.La[1] = s1;
        tl.La[0] = ~s1 & s0;
        tl.Lb[1] = ~s1;
        tl.Lb[0] = s1 & s0;
    end

`ifdef TL_CNTR_STATE_OUT_EN
    // Debug view of the state register.
    always_comb begin
        state = state_reg;
    end
`endif

endmodule

// File: tb/tb_tl_cntr.sv
// Self-checking bench for tl_cntr. A behavioural model of the light
// sequence pushes the expected lights into a queue each cycle; the
// scenario tasks pop and compare after every clock edge.
module tb_tl_cntr;

    logic clk;
    logic reset_n;

    tl_cntr_if tl ();

`ifdef TL_CNTR_STATE_OUT_EN
    logic [1:0] state;
`endif

    tl_cntr dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tl      (tl)
`ifdef TL_CNTR_STATE_OUT_EN
        ,
        .state   (state)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state and scoreboard of expected {state, La, Lb}.
    logic [1:0] m_state;
    logic [5:0] exp_q[$];
    logic [5:0] exp_v;

    // Lights for a given state: {La, Lb}.
    function automatic logic [3:0] lights(input logic [1:0] st);
        case (st)
            2'd0:    lights = 4'b00_10;
            2'd1:    lights = 4'b01_10;
            2'd2:    lights = 4'b10_00;
            default: lights = 4'b10_01;
        endcase
    endfunction

    // Drive one cycle of stimulus, advance the model, push the expectation,
    // and step past the clock edge.
    task automatic drive(input logic r, input logic ta, input logic tb);
        reset_n = r;
        tl.Ta   = ta;
        tl.Tb   = tb;
        if (r) begin
            m_state = 2'd0;
        end else begin
            case (m_state)
                2'd0:    m_state = ta ? 2'd0 : 2'd1;
                2'd1:    m_state = 2'd2;
                2'd2:    m_state = tb ? 2'd2 : 2'd3;
                default: m_state = 2'd0;
            endcase
        end
        exp_q.push_back({m_state, lights(m_state)});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Two reset edges with no traffic: S0 lights after the first, held.
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            checks++;
            if ({tl.La, tl.Lb} !== exp_v[3:0]) begin
                errors++;
                $display("FAIL reset cyc=%0d got La=%b Lb=%b want La=%b Lb=%b",
                         cyc, tl.La, tl.Lb, exp_v[3:2], exp_v[1:0]);
            end else begin
                $display("cyc=%0d reset La=%b Lb=%b", cyc, tl.La, tl.Lb);
            end
`ifdef TL_CNTR_STATE_OUT_EN
            checks++;
            if (state !== exp_v[5:4]) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got %b want %b", cyc, state, exp_v[5:4]);
            end
`endif
        end
    endtask

    // Released from reset with traffic on A: A keeps green.
    task automatic test_hold_a();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, (i == 1) ? 1'b1 : 1'b0);
            exp_v = exp_q.pop_front();
            checks++;
            if ({tl.La, tl.Lb} !== exp_v[3:0]) begin
                errors++;
                $display("FAIL hold_a cyc=%0d got La=%b Lb=%b want La=%b Lb=%b",
                         cyc, tl.La, tl.Lb, exp_v[3:2], exp_v[1:0]);
            end else begin
                $display("cyc=%0d hold_a La=%b Lb=%b", cyc, tl.La, tl.Lb);
            end
        end
    endtask

    // A empties, B has traffic: yellow for one cycle then B green, held
    // while Tb=1 (including with Ta=1 as well).
    task automatic test_a_to_b();
        logic [1:0] ta_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, ta_tab[i], 1'b1);
            exp_v = exp_q.pop_front();
            checks++;
            if ({tl.La, tl.Lb} !== exp_v[3:0]) begin
                errors++;
                $display("FAIL a_to_b cyc=%0d got La=%b Lb=%b want La=%b Lb=%b",
                         cyc, tl.La, tl.Lb, exp_v[3:2], exp_v[1:0]);
            end else begin
                $display("cyc=%0d a_to_b La=%b Lb=%b", cyc, tl.La, tl.Lb);
            end
        end
    endtask

    // In S2, B empties: B yellow one cycle (Ta=1 ignored there), then A green.
    task automatic test_b_to_a();
        logic [1:0] ta_tab [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, ta_tab[i], 1'b0);
            exp_v = exp_q.pop_front();
            checks++;
            if ({tl.La, tl.Lb} !== exp_v[3:0]) begin
                errors++;
                $display("FAIL b_to_a cyc=%0d got La=%b Lb=%b want La=%b Lb=%b",
                         cyc, tl.La, tl.Lb, exp_v[3:2], exp_v[1:0]);
            end else begin
                $display("cyc=%0d b_to_a La=%b Lb=%b", cyc, tl.La, tl.Lb);
            end
        end
    endtask

    // No traffic at all: four-state loop, one cycle per state.
    task automatic test_free_run();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            checks++;
            if ({tl.La, tl.Lb} !== exp_v[3:0]) begin
                errors++;
                $display("FAIL free_run cyc=%0d got La=%b Lb=%b want La=%b Lb=%b",
                         cyc, tl.La, tl.Lb, exp_v[3:2], exp_v[1:0]);
            end else begin
                $display("cyc=%0d free_run La=%b Lb=%b", cyc, tl.La, tl.Lb);
            end
`ifdef TL_CNTR_STATE_OUT_EN
            checks++;
            if (state !== exp_v[5:4]) begin
                errors++;
                $display("FAIL free_run_state cyc=%0d got %b want %b", cyc, state, exp_v[5:4]);
            end
`endif
        end
    endtask

    // Reach S2 with B traffic, then reset with Tb still 1: back to S0.
    task automatic test_reset_mid();
        logic r_tab  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic tb_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(r_tab[i], 1'b0, tb_tab[i]);
            exp_v = exp_q.pop_front();
            checks++;
            if ({tl.La, tl.Lb} !== exp_v[3:0]) begin
                errors++;
                $display("FAIL reset_mid cyc=%0d got La=%b Lb=%b want La=%b Lb=%b",
                         cyc, tl.La, tl.Lb, exp_v[3:2], exp_v[1:0]);
            end else begin
                $display("cyc=%0d reset_mid La=%b Lb=%b", cyc, tl.La, tl.Lb);
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        tl.Ta   = 1'b0;
        tl.Tb   = 1'b0;
        m_state = 2'd0;
        #2;
        test_reset();
        test_hold_a();
        test_a_to_b();
        test_b_to_a();
        test_free_run();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
